// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder sequencing controller.
package serial_adder_pkg;

    localparam int DEF_WIDTH = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_CLEAR = 2'd1;
    localparam state_t ST_SHIFT = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    // Keep at least one counter bit even for a degenerate 1-bit datapath.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_piso.sv
// Parallel-load, shift-right register; serial output is bit 0 (LSB first).
module op_piso
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             sout
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    // Load wins over shift so a new operand is never corrupted on its capture edge.
    always_comb begin
        shreg_d = shreg_q;
        if (load) begin
            shreg_d = din;
        end else if (shift) begin
            shreg_d = shreg_q >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign sout = shreg_q[0];

endmodule

// File: rtl/serial_adder_ctrl.sv
// Sequencer for the 4-bit serial adder/accumulator: accepts an operand, optionally
// clears the datapath, then streams the operand LSB-first with SE held for WIDTH clocks.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   IDLE     | waiting for op_valid; op_ready high
//   CLEAR    | one cycle with dp_rstn low (A, B and carry cleared)
//   SHIFT    | WIDTH cycles with dp_se high, dp_si = next operand bit
//   DONE     | one-cycle done pulse; overflow already holds MSB carry-out
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [WIDTH-1:0] op_data,
    input  logic             op_clr,
    output logic             op_ready,
    input  logic             dp_cout,
    output logic             dp_si,
    output logic             dp_se,
    output logic             dp_rstn,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             overflow_q;
    logic             overflow_d;

    logic             hs;
    logic             sh_load;
    logic             sh_shift;
    logic             sh_sout;

    assign hs = op_valid & op_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        overflow_d = overflow_q;
        sh_load    = 1'b0;
        sh_shift   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    sh_load = 1'b1;
                    cnt_d   = '0;
                    state_d = op_clr ? ST_CLEAR : ST_SHIFT;
                end
            end
            ST_CLEAR: begin
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                sh_shift = 1'b1;
                // Last shift: the adder is summing the MSBs, so Cout is the overflow.
                if (cnt_q == CNT_LAST) begin
                    overflow_d = dp_cout;
                    cnt_d      = '0;
                    state_d    = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
        end
    end

    op_piso #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clk   (clk),
        .rst   (rst),
        .load  (sh_load),
        .shift (sh_shift),
        .din   (op_data),
        .sout  (sh_sout)
    );

    // All outputs decode registered state; rst only gates the ready/clear strobes.
    assign op_ready = (state_q == ST_IDLE) & ~rst;
    assign busy     = (state_q == ST_CLEAR) | (state_q == ST_SHIFT);
    assign dp_se    = (state_q == ST_SHIFT);
    assign dp_si    = (state_q == ST_SHIFT) ? sh_sout : 1'b0;
    assign dp_rstn  = ~(rst | (state_q == ST_CLEAR));
    assign done     = (state_q == ST_DONE);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl with a behavioural serial adder datapath and a scoreboard.
module tb_serial_adder_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         op_valid;
    logic [W-1:0] op_data;
    logic         op_clr;
    logic         op_ready;
    logic         dp_cout;
    logic         dp_si;
    logic         dp_se;
    logic         dp_rstn;
    logic         busy;
    logic         done;
    logic         overflow;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op_data  (op_data),
        .op_clr   (op_clr),
        .op_ready (op_ready),
        .dp_cout  (dp_cout),
        .dp_si    (dp_si),
        .dp_se    (dp_se),
        .dp_rstn  (dp_rstn),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    // Serial adder datapath: A accumulates A+B serially while B takes SI.
    logic [W-1:0] dp_a;
    logic [W-1:0] dp_b;
    logic         dp_c;
    assign dp_cout = (dp_a[0] & dp_b[0]) | (dp_c & (dp_a[0] ^ dp_b[0]));
    always @(posedge clk) begin
        if (!dp_rstn) begin
            dp_a <= '0;
            dp_b <= '0;
            dp_c <= 1'b0;
        end else if (dp_se) begin
            dp_a <= {dp_a[0] ^ dp_b[0] ^ dp_c, dp_a[W-1:1]};
            dp_b <= {dp_si, dp_b[W-1:1]};
            dp_c <= dp_cout;
        end
    end

    typedef struct packed {
        logic [3:0]  a;
        logic [3:0]  b;
        logic        ovf;
        logic [3:0]  si;
        logic [7:0]  se;
        logic [7:0]  rl;
        logic [31:0] edg;
    } rec_t;

    rec_t exp_q[$];
    rec_t obs_q[$];
    int   hs_edge[$];
    int   edge_cnt   = 0;
    int   hs_count   = 0;
    int   done_count = 0;
    int   checks     = 0;
    int   errors     = 0;

    logic [3:0] m_a, m_b;
    logic       m_c;
    logic [4:0] m_full;
    logic [3:0] acc_si;
    logic [7:0] acc_se, acc_rl;
    rec_t       m_e, m_o;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Monitor: away from the active edge, record handshakes (and predict), and record completions.
    always @(negedge clk) begin
        if (rst) begin
            m_a = '0; m_b = '0; m_c = 1'b0;
            exp_q.delete();
            acc_si = '0; acc_se = '0; acc_rl = '0;
        end else begin
            if (dp_se) begin
                acc_se = acc_se + 8'd1;
                acc_si = {dp_si, acc_si[3:1]};
            end
            if (!dp_rstn) acc_rl = acc_rl + 8'd1;
            if (done) begin
                m_o.a = dp_a; m_o.b = dp_b; m_o.ovf = overflow;
                m_o.si = acc_si; m_o.se = acc_se; m_o.rl = acc_rl;
                m_o.edg = 32'(edge_cnt);
                obs_q.push_back(m_o);
                done_count++;
            end
            if (op_valid && op_ready) begin
                if (op_clr) begin
                    m_a = '0; m_b = '0; m_c = 1'b0;
                end
                m_full = {1'b0, m_a} + {1'b0, m_b} + {4'b0, m_c};
                m_a = m_full[3:0];
                m_c = m_full[4];
                m_b = op_data;
                m_e.a = m_a; m_e.b = m_b; m_e.ovf = m_c;
                m_e.si = op_data; m_e.se = 8'd4;
                m_e.rl = op_clr ? 8'd1 : 8'd0;
                m_e.edg = 32'(edge_cnt + 1 + W) + {31'b0, op_clr};
                exp_q.push_back(m_e);
                hs_edge.push_back(edge_cnt + 1);
                hs_count++;
                acc_si = '0; acc_se = '0; acc_rl = '0;
            end
        end
    end

    function automatic string fmt(input rec_t r);
        return $sformatf("a=%b b=%b ovf=%b si=%b se=%0d rl=%0d edge=%0d",
                         r.a, r.b, r.ovf, r.si, r.se, r.rl, r.edg);
    endfunction

    task automatic drive_op(input logic [3:0] d, input logic c);
        int start;
        int n;
        @(posedge clk); #1;
        op_valid = 1'b1; op_data = d; op_clr = c;
        start = hs_count;
        n = 0;
        while (hs_count == start && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        if (hs_count == start) begin
            checks++; errors++;
            $display("FAIL handshake_timeout: got no handshake in %0d cycles, want one", n);
        end
        @(posedge clk); #1;
        op_valid = 1'b0;
        op_data  = 4'($urandom);
        op_clr   = 1'($urandom);
    endtask

    task automatic wait_done(output rec_t o, output rec_t e, output bit ok);
        int n = 0;
        while (obs_q.size() == 0 && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        ok = 1'b0;
        o = '0;
        e = '0;
        if (obs_q.size() == 0 || exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL done_timeout: got obs=%0d exp=%0d queued, want both nonzero",
                     obs_q.size(), exp_q.size());
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; op_valid = 1'b1; op_data = 4'hF; op_clr = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({op_ready, busy, done, dp_se, dp_si, dp_rstn, overflow} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b busy=%b done=%b se=%b si=%b rstn=%b ovf=%b, want all 0",
                     op_ready, busy, done, dp_se, dp_si, dp_rstn, overflow);
        end
        @(posedge clk); #1;
        rst = 1'b0; op_valid = 1'b0;
        @(negedge clk); #1;
        checks++;
        if ({op_ready, busy, dp_rstn} !== 3'b101) begin
            errors++;
            $display("FAIL post_reset: got rdy=%b busy=%b rstn=%b, want 1 0 1", op_ready, busy, dp_rstn);
        end
        checks++;
        if (hs_count !== 0) begin
            errors++;
            $display("FAIL reset_no_hs: got %0d handshakes, want 0", hs_count);
        end
    endtask

    task automatic test_basic();
        logic [3:0] ops [3]   = '{4'b0011, 4'b0101, 4'b0000};
        logic [3:0] a_exp [3] = '{4'b0000, 4'b0011, 4'b1000};
        rec_t o, e;
        bit ok;
        for (int i = 0; i < 3; i++) begin
            drive_op(ops[i], 1'b0);
            wait_done(o, e, ok);
            if (ok) begin
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL basic_sb[%0d]: got %s, want %s", i, fmt(o), fmt(e));
                end
                checks++;
                if ({o.a, o.ovf} !== {a_exp[i], 1'b0}) begin
                    errors++;
                    $display("FAIL basic_acc[%0d]: got a=%b ovf=%b, want a=%b ovf=0", i, o.a, o.ovf, a_exp[i]);
                end
            end
        end
        checks++;
        if (dp_b !== 4'b0000) begin
            errors++;
            $display("FAIL basic_flush: got b=%b, want 0000", dp_b);
        end
    endtask

    task automatic test_overflow();
        logic [3:0] ops [4]   = '{4'b1100, 4'b0000, 4'b0000, 4'b0000};
        logic       clr [4]   = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [3:0] a_exp [4] = '{4'b1000, 4'b0100, 4'b0101, 4'b0000};
        logic       v_exp [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        rec_t o, e;
        bit ok;
        for (int i = 0; i < 4; i++) begin
            drive_op(ops[i], clr[i]);
            if (i == 2) begin
                @(negedge clk); #1;
                checks++;
                if ({dp_se, overflow} !== 2'b11) begin
                    errors++;
                    $display("FAIL ovf_hold: got se=%b ovf=%b mid-op, want 1 1", dp_se, overflow);
                end
            end
            wait_done(o, e, ok);
            if (ok) begin
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL ovf_sb[%0d]: got %s, want %s", i, fmt(o), fmt(e));
                end
                checks++;
                if ({o.a, o.ovf} !== {a_exp[i], v_exp[i]}) begin
                    errors++;
                    $display("FAIL ovf_acc[%0d]: got a=%b ovf=%b, want a=%b ovf=%b",
                             i, o.a, o.ovf, a_exp[i], v_exp[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int start;
        int n;
        int k;
        rec_t o, e;
        bit ok;
        start = hs_count;
        n = 0;
        @(posedge clk); #1;
        op_valid = 1'b1; op_clr = 1'b0; op_data = 4'($urandom);
        while (hs_count - start < 3 && n < 60) begin
            @(posedge clk); #1;
            op_data = 4'($urandom);
            n++;
        end
        op_valid = 1'b0;
        checks++;
        if (hs_count - start !== 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d handshakes, want 3", hs_count - start);
        end
        for (int i = 0; i < 3; i++) begin
            wait_done(o, e, ok);
            if (ok) begin
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL b2b_sb[%0d]: got %s, want %s", i, fmt(o), fmt(e));
                end
            end
        end
        k = hs_edge.size();
        for (int i = 1; i < 3; i++) begin
            checks++;
            if (hs_edge[k-i] - hs_edge[k-i-1] !== 6) begin
                errors++;
                $display("FAIL b2b_spacing[%0d]: got %0d cycles, want 6", i, hs_edge[k-i] - hs_edge[k-i-1]);
            end
        end
    endtask

    task automatic test_rst_mid_shift();
        logic [3:0] ops [3] = '{4'b1111, 4'b1111, 4'b0000};
        logic       clr [3] = '{1'b1, 1'b0, 1'b0};
        rec_t o, e;
        bit ok;
        int dc;
        int rel_edge;
        int start;
        int n;
        for (int i = 0; i < 3; i++) begin
            drive_op(ops[i], clr[i]);
            wait_done(o, e, ok);
            if (ok) begin
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL abort_prep[%0d]: got %s, want %s", i, fmt(o), fmt(e));
                end
            end
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL abort_prep_ovf: got ovf=%b, want 1", overflow);
        end
        drive_op(4'b0101, 1'b0);
        @(negedge clk); #1;
        checks++;
        if (dp_se !== 1'b1) begin
            errors++;
            $display("FAIL abort_se1: got se=%b, want 1", dp_se);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        dc = done_count;
        @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if ({dp_se, done, busy, dp_rstn, overflow, dp_a, dp_b} !== 13'b0) begin
            errors++;
            $display("FAIL abort_state: got se=%b done=%b busy=%b rstn=%b ovf=%b a=%b b=%b, want all 0",
                     dp_se, done, busy, dp_rstn, overflow, dp_a, dp_b);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        op_valid = 1'b1; op_data = 4'b0110; op_clr = 1'b0;
        rel_edge = edge_cnt;
        start = hs_count;
        @(negedge clk); #1;
        checks++;
        if (op_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_ready: got rdy=%b, want 1", op_ready);
        end
        n = 0;
        while (hs_count == start && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        op_valid = 1'b0;
        checks++;
        if (hs_count == start || hs_edge[hs_edge.size()-1] !== rel_edge + 1) begin
            errors++;
            $display("FAIL abort_first_hs: got hs=%0d edge=%0d, want edge=%0d",
                     hs_count - start, hs_edge[hs_edge.size()-1], rel_edge + 1);
        end
        checks++;
        if (done_count !== dc) begin
            errors++;
            $display("FAIL abort_no_done: got %0d done pulses, want 0", done_count - dc);
        end
        wait_done(o, e, ok);
        if (ok) begin
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL abort_resume: got %s, want %s", fmt(o), fmt(e));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_back_to_back();
        test_rst_mid_shift();
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
